formation_marcher: RTL and testbench

Parametrised alien-formation controller for an arbitrary NUM_ROWS × NUM_COLUMNS grid. It owns per-alien alive state, accepts indexed hits, and marches the whole formation Space-Invaders style: horizontal steps, a descent at the screen edges, and a step rate that speeds up as aliens die. It computes the armed (bottom-most alive) mask, detects cleared and landed conditions, and produces a registered alien pixel for the VGA compositor.

---
 rtl/formation_marcher_if.sv | 38 +++
 rtl/formation_marcher.sv | 200 ++++++++++++++++++++
 tb/tb_formation_marcher.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/formation_marcher_if.sv
// Host-side bundle for the alien formation controller: video scan, hit
// requests, restart, and the formation status returned to the host.
interface formation_marcher_if #(
    parameter int NUM_ROWS    = 3,
    parameter int NUM_COLUMNS = 5
);
    localparam int CNT_W = $clog2(NUM_ROWS * NUM_COLUMNS + 1);

    logic                                 frame_tick;
    logic [15:0]                          scan_x;
    logic [15:0]                          scan_y;
    logic                                 hit_valid;
    logic [15:0]                          hit_row;
    logic [15:0]                          hit_col;
    logic                                 restart;
    logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] alive_matrix;
    logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] armed_matrix;
    logic [15:0]                          origin_x;
    logic [15:0]                          origin_y;
    logic [CNT_W-1:0]                     alive_count;
    logic                                 hit_accepted;
    logic                                 step_pulse;
    logic                                 cleared;
    logic                                 landed;
    logic                                 alien_pixel;

    modport master (
        output frame_tick, scan_x, scan_y, hit_valid, hit_row, hit_col, restart,
        input  alive_matrix, armed_matrix, origin_x, origin_y, alive_count,
               hit_accepted, step_pulse, cleared, landed, alien_pixel
    );

    modport slave (
        input  frame_tick, scan_x, scan_y, hit_valid, hit_row, hit_col, restart,
        output alive_matrix, armed_matrix, origin_x, origin_y, alive_count,
               hit_accepted, step_pulse, cleared, landed, alien_pixel
    );
endinterface

// File: rtl/formation_marcher.sv
// Space-Invaders style formation: alive bookkeeping, indexed hits, edge-bounce
// marching with alive-count dependent speed, terminal flags and sprite pixel.
module formation_marcher #(
    parameter int NUM_ROWS         = 3,
    parameter int NUM_COLUMNS      = 5,
    parameter int START_X          = 100,
    parameter int START_Y          = 50,
    parameter int SPACING_X        = 64,
    parameter int SPACING_Y        = 32,
    parameter int ALIEN_W          = 32,
    parameter int ALIEN_H          = 16,
    parameter int STEP_X           = 8,
    parameter int STEP_Y           = 16,
    parameter int LEFT_BOUND       = 16,
    parameter int RIGHT_BOUND      = 624,
    parameter int LAND_Y           = 400,
    parameter int MIN_PERIOD       = 2,
    parameter int PERIOD_PER_ALIEN = 2
) (
    input logic               clk,
    input logic               rst_n,
    formation_marcher_if.slave bus
);
    localparam int               CNT_W = $clog2(NUM_ROWS * NUM_COLUMNS + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(NUM_ROWS * NUM_COLUMNS);
    localparam logic [15:0] SX16  = 16'(SPACING_X);
    localparam logic [15:0] SY16  = 16'(SPACING_Y);
    localparam logic [15:0] AW16  = 16'(ALIEN_W);
    localparam logic [15:0] AH16  = 16'(ALIEN_H);
    localparam logic [15:0] STX16 = 16'(STEP_X);
    localparam logic [15:0] STY16 = 16'(STEP_Y);

    typedef enum logic {MARCH, HALT} state_t;
    state_t state, state_nxt;
    logic   marching;

    logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] alive, alive_nxt, armed;
    logic [NUM_COLUMNS-1:0] col_any, below;
    logic [NUM_ROWS-1:0]    row_any;
    logic [CNT_W-1:0]       count;
    logic [15:0] origin_x, origin_y, ox_nxt, oy_nxt, timer, timer_nxt, period;
    logic [15:0] left_col, right_col, low_row, lx, rx;
    logic        dir_right, dir_nxt;
    logic        hit_ok, step_ok, cleared, landed, cleared_nxt, landed_nxt;
    logic        hit_accepted, step_pulse, pix_p0, pix_p1;

    function automatic logic in_span(input logic [15:0] v, input logic [15:0] lo,
                                     input logic [15:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           state <= MARCH;
        else if (bus.restart) state <= MARCH;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MARCH:   if (cleared_nxt || landed_nxt) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = MARCH;
        endcase
    end

    always_comb marching = (state == MARCH);

    // Extents of the surviving formation drive both edge detection and landing.
    always_comb begin
        col_any   = '0;
        row_any   = '0;
        left_col  = '0;
        right_col = '0;
        low_row   = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLUMNS; c++) begin
                col_any[c] = col_any[c] | alive[r][c];
                row_any[r] = row_any[r] | alive[r][c];
            end
        for (int c = NUM_COLUMNS - 1; c >= 0; c--) if (col_any[c]) left_col = 16'(c);
        for (int c = 0; c < NUM_COLUMNS; c++)      if (col_any[c]) right_col = 16'(c);
        for (int r = 0; r < NUM_ROWS; r++)         if (row_any[r]) low_row = 16'(r);
    end

    always_comb begin
        period    = 16'(MIN_PERIOD) + 16'(count) * 16'(PERIOD_PER_ALIEN);
        step_ok   = marching && bus.frame_tick && (timer >= period - 16'd1);
        timer_nxt = timer;
        if (marching && bus.frame_tick) timer_nxt = step_ok ? 16'd0 : timer + 16'd1;
        lx      = origin_x + left_col * SX16;
        rx      = origin_x + right_col * SX16;
        ox_nxt  = origin_x;
        oy_nxt  = origin_y;
        dir_nxt = dir_right;
        if (step_ok) begin
            if (dir_right) begin
                if (rx + AW16 + STX16 > 16'(RIGHT_BOUND)) begin
                    oy_nxt  = origin_y + STY16;
                    dir_nxt = 1'b0;
                end else begin
                    ox_nxt = origin_x + STX16;
                end
            end else begin
                if (lx < 16'(LEFT_BOUND) + STX16) begin
                    oy_nxt  = origin_y + STY16;
                    dir_nxt = 1'b1;
                end else begin
                    ox_nxt = origin_x - STX16;
                end
            end
        end
        landed_nxt = landed | (step_ok && (oy_nxt + low_row * SY16 + AH16 >= 16'(LAND_Y)));
    end

    // Out-of-range indices simply never match any (r,c) and fall through as ignored.
    always_comb begin
        alive_nxt = alive;
        hit_ok    = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLUMNS; c++)
                if (marching && bus.hit_valid && bus.hit_row == 16'(r) &&
                    bus.hit_col == 16'(c) && alive[r][c]) begin
                    hit_ok          = 1'b1;
                    alive_nxt[r][c] = 1'b0;
                end
        cleared_nxt = cleared | (hit_ok && count == CNT_W'(1));
    end

    always_comb begin
        armed = '0;
        below = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--)
            for (int c = 0; c < NUM_COLUMNS; c++) begin
                armed[r][c] = alive[r][c] & ~below[c];
                below[c]    = below[c] | alive[r][c];
            end
    end

    always_comb begin
        pix_p0 = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLUMNS; c++)
                if (alive[r][c] &&
                    in_span(bus.scan_x, origin_x + 16'(c) * SX16, AW16) &&
                    in_span(bus.scan_y, origin_y + 16'(r) * SY16, AH16))
                    pix_p0 = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive        <= '1;
            count        <= FULL;
            origin_x     <= 16'(START_X);
            origin_y     <= 16'(START_Y);
            dir_right    <= 1'b1;
            timer        <= '0;
            hit_accepted <= 1'b0;
            step_pulse   <= 1'b0;
            cleared      <= 1'b0;
            landed       <= 1'b0;
            pix_p1       <= 1'b0;
        end else if (bus.restart) begin
            alive        <= '1;
            count        <= FULL;
            origin_x     <= 16'(START_X);
            origin_y     <= 16'(START_Y);
            dir_right    <= 1'b1;
            timer        <= '0;
            hit_accepted <= 1'b0;
            step_pulse   <= 1'b0;
            cleared      <= 1'b0;
            landed       <= 1'b0;
            pix_p1       <= 1'b0;
        end else begin
            alive        <= alive_nxt;
            count        <= hit_ok ? count - CNT_W'(1) : count;
            origin_x     <= ox_nxt;
            origin_y     <= oy_nxt;
            dir_right    <= dir_nxt;
            timer        <= timer_nxt;
            hit_accepted <= hit_ok;
            step_pulse   <= step_ok;
            cleared      <= cleared_nxt;
            landed       <= landed_nxt;
            pix_p1       <= pix_p0;
        end
    end

    assign bus.alive_matrix = alive;
    assign bus.armed_matrix = armed;
    assign bus.origin_x     = origin_x;
    assign bus.origin_y     = origin_y;
    assign bus.alive_count  = count;
    assign bus.hit_accepted = hit_accepted;
    assign bus.step_pulse   = step_pulse;
    assign bus.cleared      = cleared;
    assign bus.landed       = landed;
    assign bus.alien_pixel  = pix_p1;
endmodule

// File: tb/tb_formation_marcher.sv
// Scoreboard bench for formation_marcher: a behavioural model queues the
// expected post-edge state for every driven cycle; scenario tasks check it.
module tb_formation_marcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    formation_marcher_if #(.NUM_ROWS(3), .NUM_COLUMNS(5)) bus ();
    formation_marcher dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [15:0] ox, oy;
        logic [14:0] alive, armed;
        logic [3:0]  count;
        logic        ha, sp, cl, ld, pix;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   total_steps = 0;

    int m_alive[3][5];
    int m_ox, m_oy, m_dir, m_timer, m_count;
    bit m_cl, m_ld;

    task automatic model_reset();
        for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) m_alive[r][c] = 1;
        m_ox = 100; m_oy = 50; m_dir = 1; m_timer = 0; m_count = 15;
        m_cl = 0; m_ld = 0;
    endtask

    task automatic model_cycle(input bit tk, input bit hv, input int hr, input int hc,
                               input bit rs, input int sx, input int sy, output exp_t e);
        bit halt, hit, stp, pix, below;
        int per, lc, rc, lr, bx, by;
        halt = m_cl || m_ld;
        pix = 0; hit = 0; stp = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) begin
                bx = m_ox + c * 64;
                by = m_oy + r * 32;
                if (m_alive[r][c] != 0 && sx >= bx && sx < bx + 32 && sy >= by && sy < by + 16)
                    pix = 1;
            end
        if (rs) begin
            model_reset();
            pix = 0;
        end else begin
            if (!halt && hv && hr >= 0 && hr < 3 && hc >= 0 && hc < 5)
                hit = (m_alive[hr][hc] != 0);
            per = 2 + 2 * m_count;
            stp = !halt && tk && (m_timer >= per - 1);
            if (!halt && tk) m_timer = stp ? 0 : m_timer + 1;
            if (stp) begin
                lc = 5; rc = -1; lr = -1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 5; c++)
                        if (m_alive[r][c] != 0) begin
                            if (c < lc) lc = c;
                            if (c > rc) rc = c;
                            if (r > lr) lr = r;
                        end
                if (m_dir != 0) begin
                    if (m_ox + rc * 64 + 32 + 8 > 624) begin m_oy += 16; m_dir = 0; end
                    else m_ox += 8;
                end else begin
                    if (m_ox + lc * 64 < 16 + 8) begin m_oy += 16; m_dir = 1; end
                    else m_ox -= 8;
                end
                if (m_oy + lr * 32 + 16 >= 400) m_ld = 1;
            end
            if (hit) begin
                m_alive[hr][hc] = 0;
                m_count--;
                if (m_count == 0) m_cl = 1;
            end
        end
        e.ox = 16'(m_ox); e.oy = 16'(m_oy); e.count = 4'(m_count);
        for (int c = 0; c < 5; c++) begin
            below = 0;
            for (int r = 2; r >= 0; r--) begin
                e.alive[r*5+c] = (m_alive[r][c] != 0);
                e.armed[r*5+c] = (m_alive[r][c] != 0) && !below;
                if (m_alive[r][c] != 0) below = 1;
            end
        end
        e.ha = hit; e.sp = stp; e.cl = m_cl; e.ld = m_ld; e.pix = pix;
    endtask

    task automatic drive(input bit tk, input bit hv, input int hr, input int hc, input bit rs);
        exp_t e;
        bus.frame_tick = tk; bus.hit_valid = hv;
        bus.hit_row = 16'(hr); bus.hit_col = 16'(hc); bus.restart = rs;
        model_cycle(tk, hv, hr, hc, rs, int'(bus.scan_x), int'(bus.scan_y), e);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.frame_tick = 1'b0; bus.hit_valid = 1'b0; bus.restart = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] a;
        rst_n = 1'b0; model_reset();
        repeat (3) @(posedge clk);
        #1;
        a = bus.alive_matrix;
        n_cmp++; if (a !== 15'h7FFF) begin n_fail++; $display("FAIL reset_alive: got %h want 7fff", a); end
        a = bus.armed_matrix;
        n_cmp++; if (a !== 15'h7C00) begin n_fail++; $display("FAIL reset_armed: got %h want 7c00", a); end
        n_cmp++; if (bus.alive_count !== 4'd15) begin n_fail++; $display("FAIL reset_count: got %0d want 15", bus.alive_count); end
        n_cmp++; if (bus.origin_x !== 16'd100 || bus.origin_y !== 16'd50) begin n_fail++; $display("FAIL reset_origin: got %0d,%0d want 100,50", bus.origin_x, bus.origin_y); end
        n_cmp++; if ({bus.hit_accepted, bus.step_pulse, bus.cleared, bus.landed, bus.alien_pixel} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {bus.hit_accepted, bus.step_pulse, bus.cleared, bus.landed, bus.alien_pixel}); end
        rst_n = 1'b1;
    endtask

    task automatic test_step_timing();
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0, 0);
            e = sb.pop_front();
            if (e.sp) total_steps++;
            n_cmp++; if (bus.origin_x !== e.ox || bus.step_pulse !== e.sp) begin n_fail++; $display("FAIL timing_model tick%0d: got x=%0d sp=%b want x=%0d sp=%b", i, bus.origin_x, bus.step_pulse, e.ox, e.sp); end
            n_cmp++; if (bus.origin_x !== ((i == 31) ? 16'd108 : 16'd100) || bus.step_pulse !== (i == 31)) begin n_fail++; $display("FAIL timing_const tick%0d: got x=%0d sp=%b", i, bus.origin_x, bus.step_pulse); end
        end
        drive(0, 0, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++; if (bus.step_pulse !== 1'b0) begin n_fail++; $display("FAIL timing_single_pulse: got %b want 0", bus.step_pulse); end
    endtask

    task automatic test_edge_descent();
        exp_t e;
        int cyc = 0;
        while (total_steps < 31 && cyc < 2000) begin
            drive(1, 0, 0, 0, 0);
            e = sb.pop_front();
            cyc++;
            n_cmp++; if (bus.origin_x !== e.ox || bus.origin_y !== e.oy || bus.step_pulse !== e.sp) begin n_fail++; $display("FAIL march_model cyc%0d: got %0d,%0d sp=%b want %0d,%0d sp=%b", cyc, bus.origin_x, bus.origin_y, bus.step_pulse, e.ox, e.oy, e.sp); end
            if (e.sp) begin
                total_steps++;
                if (total_steps == 29) begin
                    n_cmp++; if (bus.origin_x !== 16'd332) begin n_fail++; $display("FAIL step29_x: got %0d want 332", bus.origin_x); end
                end
                if (total_steps == 30) begin
                    n_cmp++; if (bus.origin_x !== 16'd332 || bus.origin_y !== 16'd66) begin n_fail++; $display("FAIL descent: got %0d,%0d want 332,66", bus.origin_x, bus.origin_y); end
                end
                if (total_steps == 31) begin
                    n_cmp++; if (bus.origin_x !== 16'd324 || bus.origin_y !== 16'd66) begin n_fail++; $display("FAIL after_descent: got %0d,%0d want 324,66", bus.origin_x, bus.origin_y); end
                end
            end
        end
        n_cmp++; if (total_steps < 31) begin n_fail++; $display("FAIL descent_timeout: got %0d steps want 31", total_steps); end
    endtask

    task automatic test_hit();
        exp_t e;
        logic [14:0] a, m;
        drive(0, 1, 2, 0, 0);
        e = sb.pop_front();
        a = bus.alive_matrix; m = bus.armed_matrix;
        n_cmp++; if (a !== e.alive || m !== e.armed) begin n_fail++; $display("FAIL hit_model: got alive=%h armed=%h want %h %h", a, m, e.alive, e.armed); end
        n_cmp++; if (a[10] !== 1'b0 || m[5] !== 1'b1) begin n_fail++; $display("FAIL hit_bits: got alive20=%b armed10=%b want 0 1", a[10], m[5]); end
        n_cmp++; if (bus.alive_count !== 4'd14 || bus.hit_accepted !== 1'b1) begin n_fail++; $display("FAIL hit_count: got %0d ha=%b want 14 1", bus.alive_count, bus.hit_accepted); end
        for (int i = 0; i < 30; i++) begin
            if (i == 29) drive(1, 1, 1, 1, 0);
            else drive(1, 0, 0, 0, 0);
            e = sb.pop_front();
            n_cmp++; if (bus.step_pulse !== (i == 29) || bus.step_pulse !== e.sp) begin n_fail++; $display("FAIL period30 tick%0d: got sp=%b want %b", i, bus.step_pulse, e.sp); end
        end
        n_cmp++; if (bus.hit_accepted !== 1'b1 || bus.alive_count !== 4'd13 || bus.origin_x !== e.ox) begin n_fail++; $display("FAIL hit_and_step: got ha=%b cnt=%0d x=%0d want 1 13 %0d", bus.hit_accepted, bus.alive_count, bus.origin_x, e.ox); end
        drive(0, 1, 2, 0, 0);
        e = sb.pop_front();
        n_cmp++; if (bus.hit_accepted !== 1'b0 || bus.alive_count !== e.count) begin n_fail++; $display("FAIL rehit: got ha=%b cnt=%0d want 0 %0d", bus.hit_accepted, bus.alive_count, e.count); end
        drive(0, 1, 3, 0, 0);
        e = sb.pop_front();
        a = bus.alive_matrix;
        n_cmp++; if (bus.hit_accepted !== 1'b0 || a !== e.alive || bus.alive_count !== 4'd13) begin n_fail++; $display("FAIL hit_oob_row: got ha=%b alive=%h want 0 %h", bus.hit_accepted, a, e.alive); end
        drive(0, 1, 0, 5, 0);
        e = sb.pop_front();
        n_cmp++; if (bus.hit_accepted !== 1'b0 || bus.alive_count !== 4'd13) begin n_fail++; $display("FAIL hit_oob_col: got ha=%b cnt=%0d want 0 13", bus.hit_accepted, bus.alive_count); end
    endtask

    task automatic test_pixel();
        exp_t e;
        int pts[5][3] = '{'{100, 50, 1}, '{132, 50, 0}, '{99, 65, 0}, '{131, 65, 1}, '{164, 82, 1}};
        rst_n = 1'b0; #1; model_reset();
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.scan_x = 16'(pts[i][0]); bus.scan_y = 16'(pts[i][1]);
            drive(0, 0, 0, 0, 0);
            e = sb.pop_front();
            n_cmp++; if (bus.alien_pixel !== e.pix || bus.alien_pixel !== (pts[i][2] != 0)) begin n_fail++; $display("FAIL pixel(%0d,%0d): got %b want %0d", pts[i][0], pts[i][1], bus.alien_pixel, pts[i][2]); end
        end
        bus.scan_x = 16'd0; bus.scan_y = 16'd0;
        drive(0, 1, 0, 0, 0);
        e = sb.pop_front();
        bus.scan_x = 16'd100; bus.scan_y = 16'd50;
        drive(0, 0, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++; if (bus.alien_pixel !== 1'b0 || bus.alien_pixel !== e.pix) begin n_fail++; $display("FAIL pixel_dead: got %b want 0", bus.alien_pixel); end
        bus.scan_x = 16'd0; bus.scan_y = 16'd0;
    endtask

    task automatic test_cleared_restart();
        exp_t e;
        logic [14:0] a;
        int steps = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) begin
                drive(0, 1, r, c, 0);
                e = sb.pop_front();
                n_cmp++; if (bus.hit_accepted !== e.ha || bus.alive_count !== e.count || bus.cleared !== e.cl) begin n_fail++; $display("FAIL clear_hit(%0d,%0d): got ha=%b cnt=%0d cl=%b want %b %0d %b", r, c, bus.hit_accepted, bus.alive_count, bus.cleared, e.ha, e.count, e.cl); end
            end
        n_cmp++; if (bus.cleared !== 1'b1 || bus.alive_count !== 4'd0) begin n_fail++; $display("FAIL cleared: got cl=%b cnt=%0d want 1 0", bus.cleared, bus.alive_count); end
        for (int i = 0; i < 40; i++) begin
            drive(1, 0, 0, 0, 0);
            e = sb.pop_front();
            if (bus.step_pulse) steps++;
        end
        n_cmp++; if (steps !== 0 || bus.origin_x !== e.ox) begin n_fail++; $display("FAIL halt_no_step: got %0d pulses x=%0d want 0 %0d", steps, bus.origin_x, e.ox); end
        drive(0, 0, 0, 0, 1);
        e = sb.pop_front();
        a = bus.alive_matrix;
        n_cmp++; if (a !== 15'h7FFF || bus.origin_x !== 16'd100 || bus.origin_y !== 16'd50 || bus.cleared !== 1'b0 || bus.alive_count !== 4'd15) begin n_fail++; $display("FAIL restart: got alive=%h %0d,%0d cl=%b cnt=%0d", a, bus.origin_x, bus.origin_y, bus.cleared, bus.alive_count); end
    endtask

    task automatic test_landing();
        exp_t e;
        int cyc = 0;
        int steps = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                if (!(r == 2 && c == 0)) begin
                    drive(0, 1, r, c, 0);
                    e = sb.pop_front();
                    n_cmp++; if (bus.hit_accepted !== 1'b1 || bus.alive_count !== e.count) begin n_fail++; $display("FAIL land_kill(%0d,%0d): got ha=%b cnt=%0d want 1 %0d", r, c, bus.hit_accepted, bus.alive_count, e.count); end
                end
        while (bus.landed !== 1'b1 && cyc < 20000) begin
            drive(1, 0, 0, 0, 0);
            e = sb.pop_front();
            cyc++;
            n_cmp++; if (bus.origin_x !== e.ox || bus.origin_y !== e.oy || bus.step_pulse !== e.sp || bus.landed !== e.ld) begin n_fail++; $display("FAIL land_model cyc%0d: got %0d,%0d sp=%b ld=%b want %0d,%0d %b %b", cyc, bus.origin_x, bus.origin_y, bus.step_pulse, bus.landed, e.ox, e.oy, e.sp, e.ld); end
        end
        n_cmp++; if (bus.landed !== 1'b1 || bus.origin_y !== 16'd322) begin n_fail++; $display("FAIL landed: got ld=%b y=%0d want 1 322", bus.landed, bus.origin_y); end
        drive(0, 1, 2, 0, 0);
        e = sb.pop_front();
        n_cmp++; if (bus.hit_accepted !== 1'b0 || bus.alive_count !== 4'd1) begin n_fail++; $display("FAIL land_hit_ignored: got ha=%b cnt=%0d want 0 1", bus.hit_accepted, bus.alive_count); end
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0, 0);
            e = sb.pop_front();
            if (bus.step_pulse) steps++;
        end
        n_cmp++; if (steps !== 0) begin n_fail++; $display("FAIL land_no_step: got %0d pulses want 0", steps); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [14:0] a;
        drive(0, 0, 0, 0, 1);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0);
            e = sb.pop_front();
        end
        drive(1, 1, 2, 2, 0);
        e = sb.pop_front();
        n_cmp++; if (bus.hit_accepted !== 1'b1 || bus.alive_count !== 4'd14) begin n_fail++; $display("FAIL pre_reset_hit: got ha=%b cnt=%0d want 1 14", bus.hit_accepted, bus.alive_count); end
        rst_n = 1'b0;
        #1;
        model_reset();
        a = bus.alive_matrix;
        n_cmp++; if (a !== 15'h7FFF || bus.alive_count !== 4'd15 || bus.hit_accepted !== 1'b0) begin n_fail++; $display("FAIL async_reset_hit: got alive=%h cnt=%0d ha=%b", a, bus.alive_count, bus.hit_accepted); end
        n_cmp++; if (bus.origin_x !== 16'd100 || bus.origin_y !== 16'd50 || bus.step_pulse !== 1'b0 || bus.landed !== 1'b0) begin n_fail++; $display("FAIL async_reset_state: got %0d,%0d sp=%b ld=%b", bus.origin_x, bus.origin_y, bus.step_pulse, bus.landed); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    initial begin
        bus.frame_tick = 1'b0; bus.hit_valid = 1'b0; bus.restart = 1'b0;
        bus.hit_row = 16'd0; bus.hit_col = 16'd0;
        bus.scan_x = 16'd0; bus.scan_y = 16'd0;
        test_reset();
        test_step_timing();
        test_edge_descent();
        test_hit();
        test_pixel();
        test_cleared_restart();
        test_landing();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
